// File: rtl/spi_al422_writer.sv
// SPI frame loader for the AL422B write port: bytes clocked in over SPI are written
// one by one through /WE, with /WRST at each frame start and length checking at frame end.
module spi_al422_writer #(
    parameter int FRAME_BYTES = 192,
    parameter int WRST_LOW    = 2,
    parameter int WE_LOW      = 2
) (
    input  logic       in_clk,
    input  logic       in_nrst,
    input  logic       spi_sck,
    input  logic       spi_mosi,
    input  logic       spi_cs_n,
    output logic [7:0] al422_data,
    output logic       al422_we_n,
    output logic       al422_wrst_n,
    output logic       frame_done,
    output logic       frame_err,
    output logic       overrun
);
    localparam int DATA_W  = 8;
    localparam int CNT_W   = $clog2(FRAME_BYTES + 1);
    localparam int TMR_MAX = (WRST_LOW > WE_LOW) ? WRST_LOW : WE_LOW;
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRST,
        S_ARMED,
        S_SETUP,
        S_STROBE,
        S_HOLD,
        S_END
    } state_t;

    state_t state, state_nxt;

    logic sck_p0, sck_p1, sck_p2;
    logic mosi_p0, mosi_p1;
    logic cs_p0, cs_p1, cs_p2;

    logic [DATA_W-1:0] shift_reg, hold_reg, shift_nxt;
    logic [2:0]        bit_cnt;
    logic [CNT_W-1:0]  byte_cnt;
    logic [TMR_W-1:0]  tmr, tmr_nxt;
    logic              pend, start_req, end_req, too_long;
    logic              sck_rise, cs_fall, cs_rise, shift_en, byte_done;
    logic              pend_clr, start_clr, end_clr, suppress, frame_ok;

    // stage p0/p1: two-FF synchronisers; p2: edge-detect history
    always_ff @(posedge in_clk or negedge in_nrst) begin
        if (!in_nrst) begin
            sck_p0  <= 1'b0;
            sck_p1  <= 1'b0;
            sck_p2  <= 1'b0;
            mosi_p0 <= 1'b0;
            mosi_p1 <= 1'b0;
            cs_p0   <= 1'b0;
            cs_p1   <= 1'b0;
            cs_p2   <= 1'b0;
        end else begin
            sck_p0  <= spi_sck;
            sck_p1  <= sck_p0;
            sck_p2  <= sck_p1;
            mosi_p0 <= spi_mosi;
            mosi_p1 <= mosi_p0;
            cs_p0   <= spi_cs_n;
            cs_p1   <= cs_p0;
            cs_p2   <= cs_p1;
        end
    end

    assign sck_rise  = sck_p1 & ~sck_p2;
    assign cs_fall   = ~cs_p1 & cs_p2;
    assign cs_rise   = cs_p1 & ~cs_p2;
    assign shift_en  = ~cs_p1 & sck_rise & ~cs_fall;
    assign byte_done = shift_en && (bit_cnt == 3'd7);
    assign shift_nxt = {shift_reg[DATA_W-2:0], mosi_p1};

    // SPI byte assembly and request flags
    always_ff @(posedge in_clk or negedge in_nrst) begin
        if (!in_nrst) begin
            bit_cnt   <= 3'd0;
            overrun   <= 1'b0;
            pend      <= 1'b0;
            start_req <= 1'b0;
            end_req   <= 1'b0;
        end else begin
            if (cs_fall) begin
                bit_cnt <= 3'd0;
                overrun <= 1'b0;
            end else if (cs_rise) begin
                bit_cnt <= 3'd0;
            end else if (shift_en) begin
                bit_cnt <= bit_cnt + 3'd1;
                if (byte_done && pend)
                    overrun <= 1'b1;
            end

            if (byte_done && !pend)
                pend <= 1'b1;
            else if (pend_clr)
                pend <= 1'b0;

            if (cs_fall)
                start_req <= 1'b1;
            else if (start_clr)
                start_req <= 1'b0;

            // an end request with no frame in progress is meaningless; drop it
            if (state == S_IDLE)
                end_req <= 1'b0;
            else if (cs_rise)
                end_req <= 1'b1;
            else if (end_clr)
                end_req <= 1'b0;
        end
    end

    always_ff @(posedge in_clk) begin
        if (shift_en)
            shift_reg <= shift_nxt;
        if (byte_done && !pend)
            hold_reg <= shift_nxt;
    end

    always_ff @(posedge in_clk or negedge in_nrst) begin
        if (!in_nrst) begin
            byte_cnt <= '0;
            too_long <= 1'b0;
        end else if (cs_fall) begin
            byte_cnt <= '0;
            too_long <= 1'b0;
        end else begin
            if (state == S_HOLD)
                byte_cnt <= byte_cnt + CNT_W'(1);
            if (state == S_SETUP && suppress)
                too_long <= 1'b1;
        end
    end

    assign suppress = (byte_cnt == CNT_W'(FRAME_BYTES));
    assign frame_ok = suppress && !too_long;

    always_comb begin
        state_nxt = state;
        tmr_nxt   = tmr;
        pend_clr  = 1'b0;
        start_clr = 1'b0;
        end_clr   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_req) begin
                    state_nxt = S_WRST;
                    start_clr = 1'b1;
                    tmr_nxt   = '0;
                end
            end
            S_WRST: begin
                if (tmr == TMR_W'(WRST_LOW - 1)) begin
                    state_nxt = S_ARMED;
                    tmr_nxt   = '0;
                end else begin
                    tmr_nxt = tmr + TMR_W'(1);
                end
            end
            S_ARMED: begin
                // a finished frame is judged before the next one restarts the pointer
                if (start_req && end_req) begin
                    state_nxt = S_END;
                    end_clr   = 1'b1;
                end else if (start_req) begin
                    state_nxt = S_WRST;
                    start_clr = 1'b1;
                    tmr_nxt   = '0;
                end else if (pend) begin
                    state_nxt = S_SETUP;
                end else if (end_req) begin
                    state_nxt = S_END;
                    end_clr   = 1'b1;
                end
            end
            S_SETUP: begin
                pend_clr  = 1'b1;
                tmr_nxt   = '0;
                state_nxt = suppress ? S_ARMED : S_STROBE;
            end
            S_STROBE: begin
                if (tmr == TMR_W'(WE_LOW - 1)) begin
                    state_nxt = S_HOLD;
                    tmr_nxt   = '0;
                end else begin
                    tmr_nxt = tmr + TMR_W'(1);
                end
            end
            S_HOLD:  state_nxt = S_ARMED;
            S_END:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // outputs are registered from the next state so each strobe lines up with its state
    always_ff @(posedge in_clk or negedge in_nrst) begin
        if (!in_nrst) begin
            state        <= S_IDLE;
            tmr          <= '0;
            al422_data   <= '0;
            al422_we_n   <= 1'b1;
            al422_wrst_n <= 1'b1;
            frame_done   <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            state        <= state_nxt;
            tmr          <= tmr_nxt;
            al422_we_n   <= (state_nxt != S_STROBE);
            al422_wrst_n <= (state_nxt != S_WRST);
            frame_done   <= (state_nxt == S_END) && frame_ok;
            frame_err    <= (state_nxt == S_END) && !frame_ok;
            if (state_nxt == S_SETUP)
                al422_data <= hold_reg;
        end
    end

endmodule

// File: tb/tb_spi_al422_writer.sv
// Directed bench for spi_al422_writer: full, short, long and partial frames,
// holding-register overrun and reset in the middle of a /WE strobe.
module tb_spi_al422_writer;
    localparam int FRAME_BYTES = 192;
    localparam int WRST_LOW    = 2;
    localparam int WE_LOW      = 2;
    localparam int HALF        = 5;

    logic       in_clk   = 1'b0;
    logic       in_nrst  = 1'b0;
    logic       spi_sck  = 1'b0;
    logic       spi_mosi = 1'b0;
    logic       spi_cs_n = 1'b1;
    logic [7:0] al422_data;
    logic       al422_we_n, al422_wrst_n, frame_done, frame_err, overrun;

    spi_al422_writer #(
        .FRAME_BYTES(FRAME_BYTES),
        .WRST_LOW   (WRST_LOW),
        .WE_LOW     (WE_LOW)
    ) dut (
        .in_clk      (in_clk),
        .in_nrst     (in_nrst),
        .spi_sck     (spi_sck),
        .spi_mosi    (spi_mosi),
        .spi_cs_n    (spi_cs_n),
        .al422_data  (al422_data),
        .al422_we_n  (al422_we_n),
        .al422_wrst_n(al422_wrst_n),
        .frame_done  (frame_done),
        .frame_err   (frame_err),
        .overrun     (overrun)
    );

    always #5 in_clk = ~in_clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // output monitor, sampled on the falling edge
    int         we_cnt = 0, wrst_cnt = 0, done_cnt = 0, err_cnt = 0;
    int         we_bad = 0, wrst_bad = 0, both_low = 0;
    int         we_w = 0, wrst_w = 0;
    logic       prev_we = 1'b1, prev_wrst = 1'b1;
    logic [7:0] prev_data = 8'h00;
    logic [7:0] wr_q[$];

    always @(negedge in_clk) begin
        if (!in_nrst) begin
            prev_we   <= 1'b1;
            prev_wrst <= 1'b1;
            we_w      <= 0;
            wrst_w    <= 0;
            prev_data <= al422_data;
        end else begin
            if (!al422_we_n && !al422_wrst_n)
                both_low <= both_low + 1;
            if (!al422_we_n) begin
                if (prev_we) begin
                    we_cnt <= we_cnt + 1;
                    wr_q.push_back(al422_data);
                    we_w <= 1;
                end else begin
                    we_w <= we_w + 1;
                end
                if (al422_data != prev_data)
                    we_bad <= we_bad + 1;
            end else if (!prev_we) begin
                if (we_w != WE_LOW || al422_data != prev_data)
                    we_bad <= we_bad + 1;
            end
            if (!al422_wrst_n) begin
                if (prev_wrst) begin
                    wrst_cnt <= wrst_cnt + 1;
                    wrst_w   <= 1;
                end else begin
                    wrst_w <= wrst_w + 1;
                end
            end else if (!prev_wrst) begin
                if (wrst_w != WRST_LOW)
                    wrst_bad <= wrst_bad + 1;
            end
            done_cnt  <= done_cnt + int'(frame_done);
            err_cnt   <= err_cnt + int'(frame_err);
            prev_we   <= al422_we_n;
            prev_wrst <= al422_wrst_n;
            prev_data <= al422_data;
        end
    end

    int s_we, s_wrst, s_done, s_err, s_webad, s_wrstbad, s_q;

    task automatic snap();
        s_we      = we_cnt;
        s_wrst    = wrst_cnt;
        s_done    = done_cnt;
        s_err     = err_cnt;
        s_webad   = we_bad;
        s_wrstbad = wrst_bad;
        s_q       = wr_q.size();
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge in_clk);
        #1;
    endtask

    task automatic spi_bits(input logic [7:0] b, input int nbits, input int half);
        for (int i = 7; i > 7 - nbits; i--) begin
            spi_mosi = b[i];
            wait_clk(half);
            spi_sck = 1'b1;
            wait_clk(half);
            spi_sck = 1'b0;
        end
    endtask

    task automatic run_frame(input int nbytes, input int base, input int xbits);
        spi_cs_n = 1'b0;
        wait_clk(10);
        for (int i = 0; i < nbytes; i++)
            spi_bits(8'(base + i), 8, HALF);
        if (xbits > 0)
            spi_bits(8'hFF, xbits, HALF);
        wait_clk(10);
        spi_cs_n = 1'b1;
        wait_clk(30);
    endtask

    task automatic frame_checks(input string name, input int exp_we, input int base,
                                input int exp_done, input int exp_err);
        int bad;
        bad = 0;
        for (int i = 0; i < exp_we; i++) begin
            if (s_q + i >= wr_q.size())
                bad++;
            else if (wr_q[s_q + i] != 8'(base + i))
                bad++;
        end
        check_eq({name, "_wrst_pulses"}, wrst_cnt - s_wrst, 1);
        check_eq({name, "_wrst_width"}, wrst_bad - s_wrstbad, 0);
        check_eq({name, "_we_pulses"}, we_cnt - s_we, exp_we);
        check_eq({name, "_we_timing"}, we_bad - s_webad, 0);
        check_eq({name, "_data_errors"}, bad, 0);
        check_eq({name, "_done"}, done_cnt - s_done, exp_done);
        check_eq({name, "_err"}, err_cnt - s_err, exp_err);
    endtask

    task automatic check_reset_vals(input string name);
        check_eq({name, "_data"}, al422_data, 8'h00);
        check_eq({name, "_we_n"}, al422_we_n, 1);
        check_eq({name, "_wrst_n"}, al422_wrst_n, 1);
        check_eq({name, "_done"}, frame_done, 0);
        check_eq({name, "_err"}, frame_err, 0);
        check_eq({name, "_overrun"}, overrun, 0);
    endtask

    logic seen;

    initial begin
        in_nrst = 1'b0;
        wait_clk(4);
        check_reset_vals("reset");
        in_nrst = 1'b1;
        wait_clk(5);

        snap();
        run_frame(192, 0, 0);
        frame_checks("full", 192, 0, 1, 0);
        check_eq("full_overrun", overrun, 0);

        snap();
        run_frame(10, 'h30, 0);
        frame_checks("short", 10, 'h30, 0, 1);

        snap();
        run_frame(195, 0, 0);
        frame_checks("long", 192, 0, 0, 1);

        snap();
        run_frame(5, 'hA0, 3);
        frame_checks("partial", 5, 'hA0, 0, 1);

        // bytes at sck = in_clk/2 with no frame being serviced: the second one is lost
        spi_cs_n = 1'b0;
        in_nrst  = 1'b0;
        wait_clk(3);
        in_nrst = 1'b1;
        wait_clk(4);
        snap();
        spi_bits(8'h5A, 8, 1);
        spi_bits(8'hC3, 8, 1);
        wait_clk(6);
        check_eq("ovr_flag", overrun, 1);
        check_eq("ovr_no_write", we_cnt - s_we, 0);
        spi_cs_n = 1'b1;
        wait_clk(20);
        check_eq("ovr_idle_flags", (done_cnt - s_done) + (err_cnt - s_err), 0);
        snap();
        spi_cs_n = 1'b0;
        wait_clk(20);
        check_eq("ovr_cleared", overrun, 0);
        spi_cs_n = 1'b1;
        wait_clk(30);
        frame_checks("ovr_frame", 1, 'h5A, 0, 1);

        // reset asserted while /WE is low
        snap();
        spi_cs_n = 1'b0;
        wait_clk(10);
        for (int i = 0; i < 3; i++)
            spi_bits(8'(8'h70 + i), 8, HALF);
        spi_bits(8'h73, 7, HALF);
        spi_mosi = 1'b1;
        wait_clk(HALF);
        spi_sck = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            wait_clk(1);
            if (!al422_we_n)
                seen = 1'b1;
        end
        check_eq("strobe_seen", seen, 1);
        in_nrst = 1'b0;
        #1;
        check_reset_vals("mid_strobe");
        check_eq("pre_rst_writes", we_cnt - s_we, 3);
        spi_sck = 1'b0;
        wait_clk(3);
        in_nrst = 1'b1;
        wait_clk(5);
        spi_cs_n = 1'b1;
        wait_clk(20);
        snap();
        run_frame(4, 'h11, 0);
        frame_checks("after_rst", 4, 'h11, 0, 1);

        check_eq("we_wrst_overlap", both_low, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/spi_al422_writer.md
# spi_al422_writer

Upstream frame loader for the AL422B-based LED panel driver. It receives a frame of panel pixel bytes from an external SPI master and drives the AL422B write port (D, /WE, /WRST) in the `in_clk` domain. The panel readout logic later consumes the stored frame from the read side. Frame boundaries are given by SPI chip-select: each frame restarts the AL422 write pointer, and frame-length errors are flagged.

## Interface
- FRAME_BYTES, 192, bytes per full frame (8 px × 8 rows × 3 bytes for truecolor, 1 RGB).
- WRST_LOW, 2, `in_clk` cycles /WRST held low at frame start (≥1).
- WE_LOW, 2, `in_clk` cycles /WE held low per byte (≥1).

Ports:
- in_clk  input  1  system clock.
- in_nrst  input  1  reset, asynchronous, active-low.
- spi_sck  input  1  SPI clock, mode 0, asynchronous to in_clk.
- spi_mosi  input  1  SPI data, MSB first.
- spi_cs_n  input  1  SPI chip-select, active-low; one assertion is one frame.
- al422_data  output  8  AL422 write data.
- al422_we_n  output  1  AL422 /WE.
- al422_wrst_n  output  1  AL422 /WRST.
- frame_done  output  1  1-cycle pulse when a frame ends with exactly FRAME_BYTES bytes.
- frame_err  output  1  1-cycle pulse when a frame ends with any other byte count.
- overrun  output  1  sticky flag: a byte was lost because the holding register was full; cleared at the next frame start.

## Operation
- spi_sck, spi_mosi and spi_cs_n each pass through a 2-FF synchroniser plus one history FF for edge detection. All SPI events are taken from the synchronised signals.
- While cs_n is low, each rising sck shifts mosi into an 8-bit shift register, MSB first, and advances a 3-bit bit counter.
- On the 8th bit, the assembled byte is loaded into the holding register and `pend` is set.
  - If `pend` is already set at that moment, the byte is dropped and overrun is set.
- Falling cs_n (frame start):
  - clear bit counter, byte counter and overrun;
  - request a pointer reset.
- Rising cs_n (frame end):
  - discard any partial byte (bit counter ≠ 0);
  - request end-of-frame evaluation.
- Byte counter width is $clog2(FRAME_BYTES+1). It saturates at FRAME_BYTES.
  - Bytes arriving once the counter equals FRAME_BYTES are consumed (pend cleared) but produce no /WE strobe, and they mark the frame as too long.
- FSM states and transitions:
  - IDLE: wait for start request.
  - WRST: /WRST low for WRST_LOW cycles, then ARMED.
  - ARMED:
    - if a start request is pending → WRST;
    - else if pend is set → SETUP;
    - else if an end request is pending → END.
  - SETUP: drive al422_data from the holding register, clear pend, /WE high. Next state is STROBE, or ARMED if the write is suppressed.
  - STROBE: /WE low for WE_LOW cycles.
  - HOLD: /WE high with data held for 1 cycle; increment byte counter; then ARMED.
  - END: pulse frame_done or frame_err for 1 cycle, then IDLE.
- Start and end requests are latched flags. They are serviced only from ARMED or IDLE, so an in-flight write always completes first.
- A start request seen in IDLE goes straight to WRST. A start request during a write is serviced after HOLD.
- If a start arrives while an end request is still pending, the end is evaluated first (END), then WRST.

## Timing
- Reset values: al422_data=0x00, al422_we_n=1, al422_wrst_n=1, frame_done=0, frame_err=0, overrun=0, FSM=IDLE, all counters and flags 0.
- Assertion of in_nrst forces all outputs to their reset values immediately, including mid-write or mid-/WRST.
- SPI edge to internal event: 3 in_clk cycles.
- Per-byte write cost: 2+WE_LOW cycles (4 at default).
- Throughput constraint: the SPI byte period must exceed that cost plus 3 cycles. This requires in_clk ≥ 8× sck, with margin.
- Data timing relative to /WE:
  - al422_data is stable 1 cycle before /WE falls;
  - it stays stable through /WE low;
  - it is held 1 cycle after /WE rises.
- /WRST and /WE are never low in the same cycle.
- All outputs are registered.

## Test plan
- Reset, then a 192-byte frame with byte values 0x00..0xBF:
  - /WRST low 2 cycles after cs_n falls;
  - 192 /WE pulses, each 2 cycles low;
  - al422_data sequence is 0x00..0xBF;
  - frame_done pulses once; frame_err stays 0.
- Short frame of 10 bytes → 10 /WE pulses, then frame_err pulse; frame_done stays 0.
- 195-byte frame → exactly 192 /WE pulses, then frame_err pulse.
- Frame ending after 5 whole bytes plus 3 bits → 5 writes; the partial byte is never written; frame_err pulses.
- Two bytes sent back-to-back with sck = in_clk/2 → overrun=1 and the second byte is lost.
  - The next cs_n fall clears overrun.
- Assert in_nrst during STROBE → /WE returns to 1 immediately and all outputs take reset values.
  - After release, the next frame produces a /WRST pulse and a clean write sequence.
